// File: rtl/banner_scroll_ctrl.sv
// banner_scroll_ctrl: collects ASCII digits into a banner buffer and scrolls
// them across an N_DIGITS-wide BCD display on each tick, driven by one-byte
// commands (w = write, digits, s = start/resume, p = pause, l/r = direction).
module banner_scroll_ctrl #(
    parameter int N_DIGITS  = 6,
    parameter int BUF_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  tick,
    output logic [4*N_DIGITS-1:0] bcd_set,
    output logic                  banner_write,
    output logic                  overflow,
    output logic                  cmd_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LEN_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BUF_DEPTH);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // dir encoding: 0 = LEFT (ptr increments), 1 = RIGHT (ptr decrements)
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               dir_q, dir_d;
    logic [3:0]         disp_q [N_DIGITS];
    logic [3:0]         disp_d [N_DIGITS];
    logic               banner_write_q, banner_write_d;
    logic               overflow_q, overflow_d;
    logic               cmd_err_q, cmd_err_d;

    // Digit storage; contents past len are stale and are never displayed
    logic [3:0]         mem_q [BUF_DEPTH];
    logic               wr_en;
    logic [3:0]         wr_digit;

    // Command decode
    logic               is_digit, cmd_w, cmd_s, cmd_p, cmd_l, cmd_r;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign cmd_w    = (rx_data == 8'h77);
    assign cmd_s    = (rx_data == 8'h73);
    assign cmd_p    = (rx_data == 8'h70);
    assign cmd_l    = (rx_data == 8'h6C);
    assign cmd_r    = (rx_data == 8'h72);
    assign wr_digit = rx_data[3:0];

    // Next-state, pointer/length and next display contents
    always_comb begin : next_logic
        logic             tick_ok;
        logic             show_blank;
        logic             show_write;
        logic             show_run;
        logic [PTR_W-1:0] pos;
        int               idx;

        state_d        = state_q;
        len_d          = len_q;
        ptr_d          = ptr_q;
        dir_d          = dir_q;
        overflow_d     = 1'b0;
        cmd_err_d      = 1'b0;
        wr_en          = 1'b0;
        tick_ok        = tick && (state_q == ST_RUN);
        show_blank     = 1'b0;
        show_write     = 1'b0;
        show_run       = 1'b0;
        pos            = '0;
        idx            = 0;

        if (rx_valid) begin
            if (cmd_w) begin
                state_d    = ST_WRITE;
                len_d      = '0;
                ptr_d      = '0;
                show_blank = 1'b1;
                tick_ok    = 1'b0;
            end else if (is_digit) begin
                // A coincident tick survives only an ignored digit in RUN
                if (state_q == ST_WRITE) begin
                    if (len_q < LEN_FULL) begin
                        wr_en      = 1'b1;
                        len_d      = len_q + LEN_W'(1);
                        show_write = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else if (cmd_s) begin
                tick_ok = 1'b0;
                case (state_q)
                    ST_IDLE, ST_WRITE: begin
                        if (len_q != '0) begin
                            state_d  = ST_RUN;
                            ptr_d    = '0;
                            show_run = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            show_blank = 1'b1;
                            cmd_err_d  = 1'b1;
                        end
                    end
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = state_q;
                endcase
            end else if (cmd_p) begin
                tick_ok = 1'b0;
                if (state_q == ST_RUN) begin
                    state_d = ST_PAUSE;
                end else begin
                    cmd_err_d = 1'b1;
                end
            end else if (cmd_l) begin
                dir_d = 1'b0;
            end else if (cmd_r) begin
                dir_d = 1'b1;
            end else begin
                tick_ok   = 1'b0;
                cmd_err_d = 1'b1;
            end
        end

        // Scroll step uses the direction in force before this cycle's command
        if (tick_ok) begin
            show_run = 1'b1;
            if (dir_q == 1'b0) begin
                ptr_d = (({1'b0, ptr_q} + LEN_W'(1)) == len_q) ? '0 : ptr_q + PTR_W'(1);
            end else begin
                ptr_d = (ptr_q == '0) ? PTR_W'(len_q - LEN_W'(1)) : ptr_q - PTR_W'(1);
            end
        end

        // Display: hold by default; blank, right-aligned write view, or run window
        pos = ptr_d;
        for (int k = 0; k < N_DIGITS; k++) begin
            disp_d[k] = disp_q[k];
            if (show_blank) begin
                disp_d[k] = BLANK;
            end else if (show_write) begin
                // k counts from the left, so the rightmost slot shows digit len-1
                idx = int'(len_d) - N_DIGITS + k;
                if (idx >= 0) begin
                    disp_d[k] = (wr_en && (idx == int'(len_q))) ? wr_digit
                                                                 : mem_q[idx[PTR_W-1:0]];
                end else begin
                    disp_d[k] = BLANK;
                end
            end else if (show_run) begin
                // Wrap on len so short banners repeat across the window
                disp_d[k] = mem_q[pos];
                pos = (({1'b0, pos} + LEN_W'(1)) == len_d) ? '0 : pos + PTR_W'(1);
            end
        end

        banner_write_d = (state_d == ST_WRITE);
    end

    // State, pointer, display and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            ptr_q          <= '0;
            dir_q          <= 1'b0;
            banner_write_q <= 1'b0;
            overflow_q     <= 1'b0;
            cmd_err_q      <= 1'b0;
            for (int k = 0; k < N_DIGITS; k++) begin
                disp_q[k] <= BLANK;
            end
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            ptr_q          <= ptr_d;
            dir_q          <= dir_d;
            banner_write_q <= banner_write_d;
            overflow_q     <= overflow_d;
            cmd_err_q      <= cmd_err_d;
            for (int k = 0; k < N_DIGITS; k++) begin
                disp_q[k] <= disp_d[k];
            end
        end
    end

    // Digit storage write port; reset leaves contents alone since len goes to 0
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[len_q[PTR_W-1:0]] <= wr_digit;
        end
    end

    // Pack display slots; slot 0 is the leftmost (top) nibble
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_pack
            assign bcd_set[4*(N_DIGITS-1-gi) +: 4] = disp_q[gi];
        end
    endgenerate

    assign banner_write = banner_write_q;
    assign overflow     = overflow_q;
    assign cmd_err      = cmd_err_q;

endmodule

// File: doc/banner_scroll_ctrl.md
BANNER_SCROLL_CTRL -- requirements
Module: banner_scroll_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 6: number of displayed BCD digits.
REQ-002 SHALL have parameter BUF_DEPTH, default 16: stored digit capacity; must be >= N_DIGITS and a power of two.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8: received ASCII byte.
REQ-006 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port tick, input, 1: one-cycle scroll strobe from the clock divider.
REQ-008 SHALL have port bcd_set, output, 4*N_DIGITS: registered display; the top nibble is the leftmost digit; 4'hF means blank.
REQ-009 SHALL have port banner_write, output, 1: high while in WRITE.
REQ-010 SHALL have port overflow, output, 1: one-cycle pulse when a digit is dropped.
REQ-011 SHALL have port cmd_err, output, 1: one-cycle pulse when a byte is unrecognised or illegal in the current state.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, RUN and PAUSE, with len (0..BUF_DEPTH), ptr (0..len-1) and dir (LEFT/RIGHT) registers.
REQ-013 On 'w' in any state, SHALL go to WRITE, set len=0 and ptr=0, and blank bcd_set on the next cycle.
REQ-014 On '0'-'9' in WRITE with len<BUF_DEPTH, SHALL store the digit at buf[len] and increment len.
REQ-015 On '0'-'9' in WRITE with len==BUF_DEPTH, SHALL drop the digit, pulse overflow, and leave len unchanged.
REQ-016 In WRITE, bcd_set SHALL show the last min(len,N_DIGITS) digits right-aligned, blank-padded, updated the cycle after each accepted digit.
REQ-017 On 's' in WRITE or IDLE with len>0, SHALL go to RUN with ptr=0; the next cycle bcd_set position k (k=0 leftmost) SHALL equal buf[k mod len].
REQ-018 On 's' with len==0, SHALL go to IDLE with bcd_set all-blank, and pulse cmd_err.
REQ-019 On 'p' in RUN, SHALL go to PAUSE and freeze bcd_set and ptr.
REQ-020 On 's' in PAUSE, SHALL return to RUN without resetting ptr.
REQ-021 On 'p' outside RUN, SHALL pulse cmd_err.
REQ-022 On 'l' or 'r' in any state, SHALL set dir LEFT or RIGHT respectively; the change takes effect at the next tick.
REQ-023 On tick in RUN, SHALL update ptr to (ptr+1) mod len for LEFT or (ptr+len-1) mod len for RIGHT.
REQ-024 On tick in RUN, bcd_set position k SHALL become buf[(ptr_new+k) mod len] one cycle after the tick.
REQ-025 tick SHALL be ignored in IDLE, WRITE and PAUSE.
REQ-026 If rx_valid and tick coincide, the command SHALL take priority.
REQ-027 When rx_valid and tick coincide, the tick SHALL be applied only if the command leaves the state as RUN and does not change ptr ('l', 'r', or an ignored digit).
REQ-028 A digit received in RUN, PAUSE or IDLE SHALL be ignored and SHALL pulse cmd_err.
REQ-029 Any other byte SHALL be ignored and SHALL pulse cmd_err.
REQ-030 Modulo arithmetic SHALL use len, not BUF_DEPTH, including for len < N_DIGITS, where digits repeat across the window.
REQ-031 Storage beyond len SHALL never reach bcd_set.
REQ-032 banner_write SHALL be a registered output, high on the first cycle after entering WRITE.

Reset
REQ-033 On reset, SHALL set state=IDLE, len=0, ptr=0, dir=LEFT, bcd_set all 4'hF, and banner_write, overflow and cmd_err all 0.
REQ-034 Reset SHALL take precedence over rx_valid and tick in the same cycle.
REQ-035 Reset asserted mid-WRITE or mid-RUN SHALL discard all stored digits.

Verification (N_DIGITS=6, BUF_DEPTH=16)
REQ-036 Input w,1,2,3,4,5,6,7,s then two ticks SHALL give bcd_set 123456 -> 234567 -> 345671; banner_write SHALL be high from after 'w' until 's'.
REQ-037 Input w,3,4,0,s then 'r' and one tick SHALL give 340340 -> 034034.
REQ-038 Input w plus 17 digits SHALL give one overflow pulse on the 17th digit, len=16, and the 17th digit never displayed.
REQ-039 In RUN, input 'p' then three ticks SHALL leave bcd_set unchanged; then 's' and a tick SHALL advance exactly one position from the frozen ptr.
REQ-040 Input 'x', a digit in IDLE, and 's' with len=0 SHALL each give one cmd_err pulse, with the state staying IDLE and bcd_set FFFFFF.
REQ-041 Reset asserted during RUN concurrent with a tick SHALL give bcd_set FFFFFF and IDLE next cycle; a following 's' SHALL pulse cmd_err.
